// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the two-digit display scan controller.
package digit_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BLANK0,
        SHOW0,
        BLANK1,
        SHOW1
    } scan_state_t;

    // Active-low digit selects, shared by the digit multiplexer and the anodes.
    localparam logic [1:0] SEL_DIG1 = 2'b10;
    localparam logic [1:0] SEL_DIG2 = 2'b01;
    localparam logic [1:0] SEL_OFF  = 2'b11;

    localparam int unsigned DIGIT_W = 8;

    // Slot counter width: wide enough to hold the longer of the two slot lengths.
    function automatic int unsigned slot_cnt_width(input int unsigned on_cycles,
                                                   input int unsigned blank_cycles);
        int unsigned longest;
        longest = (on_cycles > blank_cycles) ? on_cycles : blank_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer: counts up from zero after clear and flags the last cycle of a slot.
module scan_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Compared one bit wider so a zero limit reads as done instead of underflowing.
    assign done = ({1'b0, count} + (WIDTH+1)'(1)) >= {1'b0, limit};

    // Saturates at the last slot cycle so the count can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Two-digit multiplexed display scanner with blanking gaps and frame-aligned
// pattern commit so a digit never changes in the middle of a frame.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] nro1_in,
    input  logic [DIGIT_W-1:0] nro2_in,
    input  logic [1:0]         digit_en,
    output logic [1:0]         sel,
    output logic [DIGIT_W-1:0] nro1,
    output logic [DIGIT_W-1:0] nro2,
    output logic               frame_done,
    output logic               pending
);

    localparam int unsigned     CNT_W       = slot_cnt_width(ON_CYCLES, BLANK_CYCLES);
    localparam logic [CNT_W-1:0] ON_LIMIT    = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_CYCLES);
    localparam bit              NO_BLANK    = (BLANK_CYCLES == 0);

    scan_state_t        state;
    scan_state_t        state_next;
    logic [1:0]         sel_next;
    logic               frame_done_next;
    logic               commit_c;
    logic               slot_done;
    logic               timer_clear;
    logic [CNT_W-1:0]   limit_c;
    logic [DIGIT_W-1:0] pend1;
    logic [DIGIT_W-1:0] pend2;

    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .limit (limit_c),
        .done  (slot_done)
    );

    // Next-state, registered-output precompute and commit decision.
    always_comb begin
        state_next      = state;
        sel_next        = sel;
        frame_done_next = 1'b0;
        limit_c         = ON_LIMIT;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = NO_BLANK ? SHOW0 : BLANK0;
                end
            end
            BLANK0: begin
                limit_c = BLANK_LIMIT;
                if (slot_done) begin
                    state_next = SHOW0;
                end
            end
            SHOW0: begin
                if (slot_done) begin
                    state_next = NO_BLANK ? SHOW1 : BLANK1;
                end
            end
            BLANK1: begin
                limit_c = BLANK_LIMIT;
                if (slot_done) begin
                    state_next = SHOW1;
                end
            end
            SHOW1: begin
                if (slot_done) begin
                    state_next      = NO_BLANK ? SHOW0 : BLANK0;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Dropping enable abandons the frame from any state.
        if (!en) begin
            state_next      = IDLE;
            frame_done_next = 1'b0;
        end

        // sel only moves on a transition; digit_en is taken at slot entry.
        if (state_next != state) begin
            case (state_next)
                SHOW0:   sel_next = digit_en[0] ? SEL_DIG1 : SEL_OFF;
                SHOW1:   sel_next = digit_en[1] ? SEL_DIG2 : SEL_OFF;
                default: sel_next = SEL_OFF;
            endcase
        end

        commit_c    = pending && ((state == IDLE) || frame_done_next);
        timer_clear = (state_next != state) || (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            frame_done <= frame_done_next;
        end
    end

    // Pattern double-buffer: a load on a commit edge refills the pending pair
    // while the previous pending pair moves to the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            nro1    <= '0;
            nro2    <= '0;
            pend1   <= '0;
            pend2   <= '0;
            pending <= 1'b0;
        end else begin
            if (commit_c) begin
                nro1 <= pend1;
                nro2 <= pend2;
            end
            if (load) begin
                pend1   <= nro1_in;
                pend2   <= nro2_in;
                pending <= 1'b1;
            end else if (commit_c) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=1 (10-cycle frame).
module tb_digit_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] nro1_in;
    logic [7:0] nro2_in;
    logic [1:0] digit_en;
    logic [1:0] sel;
    logic [7:0] nro1;
    logic [7:0] nro2;
    logic       frame_done;
    logic       pending;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;
    bit fresh   = 1'b0;

    digit_scan_ctrl #(
        .ON_CYCLES    (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .nro1_in    (nro1_in),
        .nro2_in    (nro2_in),
        .digit_en   (digit_en),
        .sel        (sel),
        .nro1       (nro1),
        .nro2       (nro2),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame position: 0 BLANK0, 1-4 SHOW0, 5 BLANK1, 6-9 SHOW1.
    function automatic logic [1:0] exp_sel(input int p);
        if (p == 0 || p == 5) return 2'b11;
        if (p <= 4)           return digit_en[0] ? 2'b10 : 2'b11;
        return digit_en[1] ? 2'b01 : 2'b11;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_tick();
        logic fd_exp;
        tick();
        pos    = fresh ? 0 : (pos + 1) % 10;
        fd_exp = (pos == 0) && !fresh;
        fresh  = 1'b0;
        check($sformatf("sel@%0d", pos), 32'(sel), 32'(exp_sel(pos)));
        check($sformatf("frame_done@%0d", pos), 32'(frame_done), 32'(fd_exp));
    endtask

    task automatic check_data(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic ep);
        check({tag, ".nro1"}, 32'(nro1), 32'(e1));
        check({tag, ".nro2"}, 32'(nro2), 32'(e2));
        check({tag, ".pending"}, 32'(pending), 32'(ep));
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        nro1_in  = 8'h00;
        nro2_in  = 8'h00;
        digit_en = 2'b11;
        tick();
        tick();
        check("rst.sel", 32'(sel), 32'h3);
        check("rst.frame_done", 32'(frame_done), 32'h0);
        check_data("rst", 8'h00, 8'h00, 1'b0);

        // Basic scan: two full frames from IDLE.
        reset = 1'b0;
        en    = 1'b1;
        fresh = 1'b1;
        for (int i = 0; i < 20; i++) scan_tick();

        // Load mid-SHOW0: held pending until the frame end.
        for (int i = 0; i < 3; i++) scan_tick();
        load    = 1'b1;
        nro1_in = 8'hC0;
        nro2_in = 8'hF9;
        scan_tick();
        load = 1'b0;
        check_data("mid_load", 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) scan_tick();
        check_data("before_commit", 8'h00, 8'h00, 1'b1);
        scan_tick();
        check_data("commit", 8'hC0, 8'hF9, 1'b0);

        // Load on the SHOW1 exit edge while A is pending.
        for (int i = 0; i < 3; i++) scan_tick();
        load    = 1'b1;
        nro1_in = 8'hA1;
        nro2_in = 8'hA2;
        scan_tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) scan_tick();
        check_data("a_pending", 8'hC0, 8'hF9, 1'b1);
        load    = 1'b1;
        nro1_in = 8'hB1;
        nro2_in = 8'hB2;
        scan_tick();
        load = 1'b0;
        check_data("edge_load", 8'hA1, 8'hA2, 1'b1);
        for (int i = 0; i < 9; i++) scan_tick();
        check_data("b_pending", 8'hA1, 8'hA2, 1'b1);
        scan_tick();
        check_data("b_commit", 8'hB1, 8'hB2, 1'b0);

        // Digit 2 disabled for one frame.
        digit_en = 2'b01;
        for (int i = 0; i < 10; i++) scan_tick();
        digit_en = 2'b11;

        // Enable dropped in SHOW0 with a load pending.
        load    = 1'b1;
        nro1_in = 8'h12;
        nro2_in = 8'h34;
        scan_tick();
        load = 1'b0;
        scan_tick();
        en = 1'b0;
        tick();
        check("en_drop.sel", 32'(sel), 32'h3);
        check("en_drop.frame_done", 32'(frame_done), 32'h0);
        check_data("en_drop", 8'hB1, 8'hB2, 1'b1);
        tick();
        check_data("idle_commit", 8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle.sel", 32'(sel), 32'h3);
            check("idle.frame_done", 32'(frame_done), 32'h0);
        end

        // Reset in BLANK1 discards the pending pair.
        en    = 1'b1;
        fresh = 1'b1;
        for (int i = 0; i < 4; i++) scan_tick();
        load    = 1'b1;
        nro1_in = 8'h55;
        nro2_in = 8'h66;
        scan_tick();
        load = 1'b0;
        scan_tick();
        check_data("pre_reset", 8'h12, 8'h34, 1'b1);
        reset = 1'b1;
        tick();
        check("rst2.sel", 32'(sel), 32'h3);
        check("rst2.frame_done", 32'(frame_done), 32'h0);
        check_data("rst2", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        fresh = 1'b1;
        for (int i = 0; i < 11; i++) scan_tick();
        check_data("after_rst_frame", 8'h00, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 100000; clock cycles each digit is lit per slot; legal range 1 and above.
REQ-002 Parameter BLANK_CYCLES, default 1000; clock cycles with both digits dark before each slot; legal range 0 and above.
REQ-003 clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  scan enable; when low, the block holds both digits dark.
REQ-006 load  in  1  one-cycle strobe that captures nro1_in and nro2_in into the pending registers.
REQ-007 nro1_in  in  8  new pattern for digit 1.
REQ-008 nro2_in  in  8  new pattern for digit 2.
REQ-009 digit_en  in  2  per-digit enable; bit0 enables digit 1 and bit1 enables digit 2; a disabled digit keeps its slot timing but stays dark.
REQ-010 sel  out  2  active-low digit select, driving both the digit multiplexer and the anodes.
  - 2'b10 lights digit 1.
  - 2'b01 lights digit 2.
  - 2'b11 means dark.
REQ-011 nro1  out  8  committed pattern for digit 1, fed to the multiplexer.
REQ-012 nro2  out  8  committed pattern for digit 2, fed to the multiplexer.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each full scan frame.
REQ-014 pending  out  1  high while a loaded pattern pair is waiting to be committed.

Function
REQ-015 The state machine SHALL have exactly these states: IDLE, BLANK0, SHOW0, BLANK1, SHOW1.
REQ-016 IDLE: sel=2'b11; on en=1 the next state is BLANK0, or SHOW0 when BLANK_CYCLES=0.
REQ-017 BLANK0 and BLANK1 SHALL each last exactly BLANK_CYCLES cycles with sel=2'b11, then go to SHOW0 and SHOW1 respectively.
REQ-018 SHOW0 SHALL last exactly ON_CYCLES cycles.
  - sel=2'b10 if digit_en[0]=1, else sel=2'b11.
  - Next state is BLANK1, or SHOW1 when BLANK_CYCLES=0.
REQ-019 SHOW1 SHALL last exactly ON_CYCLES cycles.
  - sel=2'b01 if digit_en[1]=1, else sel=2'b11.
  - Next state is BLANK0, or SHOW0 when BLANK_CYCLES=0.
REQ-020 sel SHALL be a registered output that changes only on state transitions, never mid-slot; digit_en is sampled in the cycle of entry into SHOW0 or SHOW1.
REQ-021 The slot counter SHALL be $clog2(max(ON_CYCLES,BLANK_CYCLES)+1) bits wide, SHALL clear on every state entry, and SHALL never wrap.
REQ-022 frame_done SHALL be high for exactly the one cycle after the last SHOW1 cycle.
REQ-023 load SHALL copy nro1_in and nro2_in into the pending registers and set pending=1 on the next edge; a later load overwrites the earlier one, so the last load wins.
REQ-024 Commit SHALL happen at the SHOW1 exit edge, or on any edge while in IDLE, and only when pending=1.
  - Commit copies the pending registers to nro1 and nro2 and clears pending.
REQ-025 A load that coincides with a commit edge SHALL be captured into the pending registers with pending left at 1; the commit on that edge uses the previously pending values.
REQ-026 en=0 in any state SHALL force IDLE with sel=2'b11 on the next edge; the frame is abandoned and no frame_done pulse is produced.
REQ-027 nro1 and nro2 SHALL never change outside a commit edge, so no digit is torn mid-frame.

Reset
REQ-028 reset=1 SHALL, on the next edge and with priority over all other inputs, put the block into this state:
  - state IDLE and slot counter 0.
  - sel=2'b11 and frame_done=0.
  - nro1=0, nro2=0, pending=0, pending registers 0.
REQ-029 Reset asserted mid-slot SHALL abort the slot immediately; no commit and no frame_done pulse occur on the reset edge.

Structure
REQ-030 Package digit_scan_pkg SHALL hold:
  - the scan_state_t enum (IDLE, BLANK0, SHOW0, BLANK1, SHOW1).
  - the active-low constants SEL_DIG1=2'b10, SEL_DIG2=2'b01, SEL_OFF=2'b11.
REQ-031 Slot timing SHALL be a sub-module scan_timer: it takes clk, reset, clear and a limit, and outputs done when the count reaches limit-1.
REQ-032 digit_scan_ctrl SHALL contain no digit multiplexing; its sel, nro1 and nro2 outputs connect directly to the existing digit multiplexer.

Verification
REQ-033 The bench SHALL run with ON_CYCLES=4 and BLANK_CYCLES=1, and SHALL cover these scenarios:
  - Reset then en=1, digit_en=2'b11: sel sequence 11 (IDLE), 11, 10,10,10,10, 11, 01,01,01,01, then repeats; frame_done pulses once every 10 cycles.
  - Load with nro1_in=8'hC0 and nro2_in=8'hF9 mid-SHOW0: nro1 and nro2 hold 0 until the frame_done cycle, then show C0/F9; pending is high in between.
  - Load coinciding with the SHOW1 exit edge (A1/A2 pending, B1/B2 loaded): A1/A2 are committed and pending stays 1; B1/B2 are committed at the next frame end.
  - digit_en=2'b01: sel stays 11 for the whole SHOW1 slot; timing and frame_done period are unchanged.
  - en dropped during SHOW0: sel=11 on the next edge and no frame_done; a pending load commits one cycle later while in IDLE.
  - reset during BLANK1 with pending=1: all outputs return to their reset values and the pending load is discarded.
